jam_cost_eval: RTL and testbench

Consumer end of the permutation generator's valid/ready handshake in the JAM (job assignment) datapath. Requests permutations one at a time, sums the N worker/job costs of each from an external combinational cost ROM, and tracks the global minimum total cost and how many permutations reach it. Stops after evaluating the final (fully descending) permutation and raises `done`.

---
 rtl/jam_cost_eval_pkg.sv | 29 ++
 rtl/jam_cost_eval_min_tracker.sv | 49 ++++
 rtl/jam_cost_eval.sv | 107 ++++++++++
 tb/tb_jam_cost_eval.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jam_cost_eval_pkg.sv
// Shared JAM datapath definitions: problem size, datapath widths and the
// evaluator state encoding. Also used by the permutation generator.
package jam_pkg;

    localparam int unsigned N      = 8;
    localparam int unsigned COST_W = 7;
    localparam int unsigned IDX_W  = $clog2(N);
    localparam int unsigned SUM_W  = COST_W + IDX_W;
    localparam int unsigned CNT_W  = 16;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [SUM_W-1:0] sum_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_PERM = 3'd1,
        S_ACCUM     = 3'd2,
        S_UPDATE    = 3'd3,
        S_DONE      = 3'd4
    } state_e;

    // True when job j sits where the fully descending permutation puts it
    // for worker i. The descending permutation is the last one generated.
    function automatic logic is_desc_pos(input idx_t i, input idx_t j);
        return j == (idx_t'(N - 1) - i);
    endfunction

endpackage

// File: rtl/jam_cost_eval_min_tracker.sv
// Running minimum of permutation totals and the number of permutations
// that hit that minimum. Count saturates at all ones.
module jam_min_tracker
    import jam_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic update,
    input  sum_t sum,
    output sum_t min_cost,
    output cnt_t match_count
);

    sum_t r_min;
    cnt_t r_cnt;
    logic w_less;
    logic w_equal;
    logic w_cnt_sat;

    // Compare the finished total against the current minimum.
    always_comb begin
        w_less    = sum < r_min;
        w_equal   = sum == r_min;
        w_cnt_sat = &r_cnt;
    end

    // Clear on a new run; replace on a strictly smaller total, count ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min <= '0;
            r_cnt <= '0;
        end else if (clear) begin
            r_min <= '1;
            r_cnt <= '0;
        end else if (update) begin
            if (w_less) begin
                r_min <= sum;
                r_cnt <= cnt_t'(1);
            end else if (w_equal && !w_cnt_sat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign min_cost    = r_min;
    assign match_count = r_cnt;

endmodule

// File: rtl/jam_cost_eval.sv
// JAM cost evaluator: consumes permutations over a valid/ready handshake,
// sums N worker/job costs per permutation from a combinational ROM and
// hands each total to the minimum tracker. Stops after the descending
// permutation and holds results with done high.
module jam_cost_eval
    import jam_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              perm_ready,
    input  idx_t [N-1:0]      perm,
    output logic              perm_valid,
    output idx_t              cost_w,
    output idx_t              cost_j,
    input  logic [COST_W-1:0] cost_data,
    output logic              busy,
    output logic              done,
    output sum_t              min_cost,
    output cnt_t              match_count
);

    state_e r_state;
    idx_t   r_idx;
    sum_t   r_sum;
    logic   r_desc;

    idx_t   w_perm_j;
    logic   w_last;
    logic   w_clear;
    logic   w_update;

    // Decode state into handshake, ROM address and status outputs.
    always_comb begin
        w_perm_j   = perm[r_idx];
        w_last     = r_idx == idx_t'(N - 1);
        w_clear    = (r_state == S_IDLE) && start;
        w_update   = r_state == S_UPDATE;
        perm_valid = w_update && !r_desc;
        cost_w     = '0;
        cost_j     = '0;
        if (r_state == S_ACCUM) begin
            cost_w = r_idx;
            cost_j = w_perm_j;
        end
        busy = (r_state == S_WAIT_PERM) || (r_state == S_ACCUM) ||
               (r_state == S_UPDATE);
        done = r_state == S_DONE;
    end

    // Control FSM with the per-permutation accumulator and descending flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_sum   <= '0;
            r_desc  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_WAIT_PERM;
                    end
                end
                S_WAIT_PERM: begin
                    if (perm_ready) begin
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_desc  <= 1'b1;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    r_sum <= r_sum + sum_t'(cost_data);
                    if (!is_desc_pos(r_idx, w_perm_j)) begin
                        r_desc <= 1'b0;
                    end
                    if (w_last) begin
                        r_state <= S_UPDATE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_UPDATE: begin
                    r_state <= r_desc ? S_DONE : S_WAIT_PERM;
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    jam_min_tracker u_min_tracker (
        .clk         (clk),
        .rst         (rst),
        .clear       (w_clear),
        .update      (w_update),
        .sum         (r_sum),
        .min_cost    (min_cost),
        .match_count (match_count)
    );

endmodule

// File: tb/tb_jam_cost_eval.sv
// Bench for jam_cost_eval: a model generator feeds a chosen permutation
// sequence (identity first, descending last), a cost ROM answers the DUT,
// and a scoreboard monitor checks results whenever done rises.
module tb_jam_cost_eval;
    import jam_pkg::*;

    typedef logic [N*IDX_W-1:0] pvec_t;
    typedef struct {
        int min_c;
        int cnt;
        int pulses;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              perm_ready;
    idx_t [N-1:0]      perm;
    logic              perm_valid;
    idx_t              cost_w;
    idx_t              cost_j;
    logic [COST_W-1:0] cost_data;
    logic              busy;
    logic              done;
    sum_t              min_cost;
    cnt_t              match_count;

    logic [COST_W-1:0] cost_mem [N][N];
    pvec_t             seq[$];
    exp_t              sb_q[$];
    int                gi = 0;
    int                gen_delay = 0;
    int                total = 0;
    int                bad = 0;
    int                runs_done = 0;

    always #5 clk = ~clk;

    assign cost_data = cost_mem[cost_w][cost_j];

    jam_cost_eval dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .perm_ready  (perm_ready),
        .perm        (perm),
        .perm_valid  (perm_valid),
        .cost_w      (cost_w),
        .cost_j      (cost_j),
        .cost_data   (cost_data),
        .busy        (busy),
        .done        (done),
        .min_cost    (min_cost),
        .match_count (match_count)
    );

    task automatic check(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // ---------------- model generator ----------------
    initial begin
        perm_ready = 1'b0;
        perm = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                gi = 0;
                if (seq.size() > 0) perm = seq[0];
                perm_ready = 1'b1;
            end else if (perm_valid && perm_ready) begin
                @(posedge clk);
                #1;
                perm_ready = 1'b0;
                repeat (gen_delay + 1) @(posedge clk);
                #1;
                if (gi + 1 < seq.size()) begin
                    gi++;
                    perm = seq[gi];
                    perm_ready = 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    int   mon_cyc = 0;
    int   mon_last_acc = -100;
    int   mon_pulses = 0;
    logic mon_prev_done = 1'b0;
    exp_t mon_e;

    initial begin
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (rst) begin
                mon_pulses = 0;
                mon_prev_done = 1'b0;
                mon_last_acc = -100;
            end else begin
                if (perm_valid) begin
                    mon_pulses++;
                    check("valid_with_ready", int'(perm_ready), 1);
                end
                if (busy && cost_w == idx_t'(N - 1)) mon_last_acc = mon_cyc;
                if (done && !mon_prev_done) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got done=1 expected no result pending");
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("min_cost", int'(min_cost), mon_e.min_c);
                        check("match_count", int'(match_count), mon_e.cnt);
                        check("valid_pulses", mon_pulses, mon_e.pulses);
                        check("done_latency", mon_cyc - mon_last_acc, 2);
                        check("busy_at_done", int'(busy), 0);
                    end
                    runs_done++;
                end
                mon_prev_done = done;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic pvec_t pack(input int a[N]);
        pvec_t v = '0;
        for (int w = 0; w < N; w++) v[w*IDX_W +: IDX_W] = idx_t'(a[w]);
        return v;
    endfunction

    task automatic build_costs(input int mode);
        for (int w = 0; w < N; w++) begin
            for (int j = 0; j < N; j++) begin
                case (mode)
                    0: cost_mem[w][j] = (j == w) ? 7'd0 : 7'd1;
                    1: cost_mem[w][j] = 7'd1;
                    2: cost_mem[w][j] = (j == N - 1 - w) ? 7'd0 : 7'd5;
                    3: cost_mem[w][j] = 7'($urandom_range(127, 0));
                    default: cost_mem[w][j] = 7'($urandom_range(1, 0));
                endcase
            end
        end
    endtask

    task automatic build_seq(input int nrand);
        int    a[N];
        int    d[N];
        int    k;
        int    t;
        pvec_t v;
        pvec_t vdesc;
        seq.delete();
        for (int w = 0; w < N; w++) begin
            a[w] = w;
            d[w] = N - 1 - w;
        end
        vdesc = pack(d);
        seq.push_back(pack(a));
        for (int r = 0; r < nrand; r++) begin
            do begin
                for (int w = 0; w < N; w++) a[w] = w;
                for (int i = N - 1; i > 0; i--) begin
                    k = int'($urandom_range(i, 0));
                    t = a[i];
                    a[i] = a[k];
                    a[k] = t;
                end
                v = pack(a);
            end while (v == vdesc);
            seq.push_back(v);
        end
        seq.push_back(vdesc);
    endtask

    // Brute-force reference: total of every presented permutation.
    function automatic exp_t model();
        exp_t  e;
        pvec_t v;
        int    s;
        e.min_c = 1 << 30;
        e.cnt = 0;
        for (int k = 0; k < seq.size(); k++) begin
            v = seq[k];
            s = 0;
            for (int w = 0; w < N; w++) s += int'(cost_mem[w][v[w*IDX_W +: IDX_W]]);
            if (s < e.min_c) begin
                e.min_c = s;
                e.cnt = 1;
            end else if (s == e.min_c) begin
                e.cnt++;
            end
        end
        e.pulses = seq.size() - 1;
        return e;
    endfunction

    task automatic check_reset_vals(input string name);
        check({name, "_ctrl"}, int'({perm_valid, busy, done, cost_w, cost_j}), 0);
        check({name, "_min"}, int'(min_cost), 0);
        check({name, "_cnt"}, int'(match_count), 0);
    endtask

    task automatic apply_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals({name, "_rst"});
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (runs_done < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (runs_done < target) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
            sb_q.delete();
        end
    endtask

    task automatic run_case(input string name, input int mode, input int nrand,
                            input int delay, input bit wait_glitch, input bit reuse);
        exp_t e;
        int   target;
        int   n;
        if (!reuse) begin
            build_costs(mode);
            build_seq(nrand);
        end
        gen_delay = delay;
        apply_reset(name);
        e = model();
        sb_q.push_back(e);
        target = runs_done + 1;
        pulse_start();
        if (wait_glitch) begin
            n = 0;
            while (!(busy && !perm_ready) && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check({name, "_in_wait_perm"}, int'(busy && !perm_ready), 1);
            pulse_start();
        end
        wait_done(target, name);
        pulse_start();
        repeat (3) @(negedge clk);
        check({name, "_done_hold"}, int'({done, busy}), 2);
        check({name, "_done_min"}, int'(min_cost), e.min_c);
        check({name, "_done_cnt"}, int'(match_count), e.cnt);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        exp_t e;
        int   target;
        int   n;
        rst = 1'b1;
        start = 1'b0;
        for (int w = 0; w < N; w++)
            for (int j = 0; j < N; j++) cost_mem[w][j] = '0;

        run_case("diag",      0, 30, 0,  1'b0, 1'b0);
        run_case("diag_slow", 0, 30, 20, 1'b1, 1'b1);
        run_case("all_ones",  1, 30, 0,  1'b0, 1'b0);
        run_case("anti_diag", 2, 30, 0,  1'b0, 1'b0);
        run_case("rand_a",    3, 40, 0,  1'b0, 1'b0);
        run_case("rand_slow", 3, 25, 20, 1'b1, 1'b0);
        run_case("ties",      4, 40, 0,  1'b0, 1'b0);

        // Abort mid-ACCUM of the third permutation, then rerun.
        build_costs(3);
        build_seq(12);
        gen_delay = 0;
        apply_reset("abort_pre");
        pulse_start();
        n = 0;
        while (!(gi == 2 && busy && cost_w == idx_t'(3)) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_accum", int'(gi == 2 && cost_w == idx_t'(3)), 1);
        rst = 1'b1;
        #1;
        check_reset_vals("abort_async");
        repeat (2) @(negedge clk);
        check_reset_vals("abort_held");
        rst = 1'b0;
        e = model();
        sb_q.push_back(e);
        target = runs_done + 1;
        pulse_start();
        wait_done(target, "abort_rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
